decode_issue_stage: RTL and testbench

- Registered, handshaked RV32IM main-decode stage with a single-entry output buffer.
- Decodes a 32-bit instruction into the pipeline control bundle and flags illegal encodings.
- Holds M-extension ops for a parametrised latency so a multi-cycle MUL/DIV unit is never overrun.
- Sits between IF/ID and the ID/EX register; `flush` comes from branch/jump resolution.

---
 rtl/decode_issue_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// RV32IM main-decode stage: registered control bundle behind a valid/ready
// handshake, with a hold counter that paces M-extension ops for a multi-cycle MUL/DIV unit.
module decode_issue_stage #(
  parameter bit          ENABLE_M    = 1'b1,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        RegWrite,
  output logic [2:0]  ImmSrc,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic [1:0]  ResultSrc,
  output logic        Branch,
  output logic        Jump,
  output logic [2:0]  ALUOp,
  output logic [2:0]  LoadType,
  output logic [2:0]  StoreType,
  output logic        IsMulDiv,
  output logic        Illegal,
  output logic        busy
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_BRANCH = 3'b001;
  localparam logic [2:0] ALU_RI     = 3'b010;
  localparam logic [2:0] ALU_M      = 3'b011;
  localparam logic [2:0] ALU_LUI    = 3'b100;
  localparam logic [2:0] ALU_AUIPC  = 3'b101;
  localparam logic [2:0] ALU_JAL    = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_MDWAIT
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
    logic [2:0] load_type;
    logic [2:0] store_type;
    logic       is_muldiv;
    logic       illegal;
  } bundle_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bundle_t          bundle_q, bundle_d;

  bundle_t          dec;
  logic             dec_legal;
  logic [CNT_W-1:0] hold_len;
  logic             accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec       = '0;
    dec_legal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec_legal      = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_LOAD;
        dec.alu_op     = ALU_ADD;
        dec.load_type  = funct3;
      end
      OP_STORE: begin
        dec_legal      = (funct3 <= 3'b010);
        dec.imm_src    = IMM_S;
        dec.alu_src    = 1'b1;
        dec.mem_write  = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.store_type = funct3;
      end
      OP_REG: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_RI;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
        end else if (funct7 == F7_ALT) begin
          dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else if ((funct7 == F7_MULDIV) && ENABLE_M) begin
          dec_legal     = 1'b1;
          dec.alu_op    = ALU_M;
          dec.is_muldiv = 1'b1;
        end
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.imm_src   = IMM_I;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_RI;
        // Shift-immediates reuse imm[11:5] as funct7 and must be canonical.
        case (funct3)
          3'b001:  dec_legal = (funct7 == F7_BASE);
          3'b101:  dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        dec_legal   = !((funct3 == 3'b010) || (funct3 == 3'b011));
        dec.imm_src = IMM_B;
        dec.branch  = 1'b1;
        dec.alu_op  = ALU_BRANCH;
      end
      OP_JAL: begin
        dec_legal      = 1'b1;
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
        dec.alu_op     = ALU_JAL;
      end
      OP_JALR: begin
        dec_legal      = (funct3 == 3'b000);
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_LUI: begin
        dec_legal     = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_LUI;
      end
      OP_AUIPC: begin
        dec_legal     = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_AUIPC;
      end
      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Illegal bundles never set is_muldiv, so they always take the zero-hold path.
  always_comb begin
    hold_len = '0;
    if (dec.is_muldiv) begin
      hold_len = funct3[2] ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
    end
  end

  assign in_ready = !rst && !flush &&
                    ((state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bundle_d = bundle_q;
    if (flush) begin
      state_d  = S_EMPTY;
      cnt_d    = '0;
      bundle_d = '0;
    end else if (accept) begin
      bundle_d = dec;
      if (hold_len == '0) begin
        state_d = S_FULL;
      end else begin
        state_d = S_MDWAIT;
        cnt_d   = hold_len;
      end
    end else begin
      case (state_q)
        S_FULL: begin
          if (out_ready) state_d = S_EMPTY;
        end
        S_MDWAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FULL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      cnt_q    <= '0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign busy      = (state_q == S_MDWAIT);

  assign RegWrite  = bundle_q.reg_write;
  assign ImmSrc    = bundle_q.imm_src;
  assign ALUSrc    = bundle_q.alu_src;
  assign MemWrite  = bundle_q.mem_write;
  assign ResultSrc = bundle_q.result_src;
  assign Branch    = bundle_q.branch;
  assign Jump      = bundle_q.jump;
  assign ALUOp     = bundle_q.alu_op;
  assign LoadType  = bundle_q.load_type;
  assign StoreType = bundle_q.store_type;
  assign IsMulDiv  = bundle_q.is_muldiv;
  assign Illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: a driver pushes reference-decoded bundles on
// accept, a negedge monitor pops and compares whatever the DUT delivers.
module tb_decode_issue_stage;

  localparam int unsigned MUL_LAT = 15;
  localparam int unsigned DIV_LAT = 32;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_DIV  = 32'h023140B3;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_LW   = 32'h0000A083;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_CUST = 32'h0000000B;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
    logic [2:0] load_type;
    logic [2:0] store_type;
    logic       is_muldiv;
    logic       illegal;
  } exp_t;

  logic        clk, rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] instr;
  logic        reg_write, alu_src, mem_write, branch, jump, is_muldiv, illegal;
  logic [2:0]  imm_src, alu_op, load_type, store_type;
  logic [1:0]  result_src;

  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [31:0] instr_b;
  logic        reg_write_b, alu_src_b, mem_write_b, branch_b, jump_b, is_muldiv_b, illegal_b;
  logic [2:0]  imm_src_b, alu_op_b, load_type_b, store_type_b;
  logic [1:0]  result_src_b;

  exp_t act_a, act_b;
  assign act_a = {reg_write, imm_src, alu_src, mem_write, result_src, branch, jump,
                  alu_op, load_type, store_type, is_muldiv, illegal};
  assign act_b = {reg_write_b, imm_src_b, alu_src_b, mem_write_b, result_src_b, branch_b, jump_b,
                  alu_op_b, load_type_b, store_type_b, is_muldiv_b, illegal_b};

  decode_issue_stage #(
    .ENABLE_M(1'b1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .RegWrite(reg_write), .ImmSrc(imm_src), .ALUSrc(alu_src), .MemWrite(mem_write),
    .ResultSrc(result_src), .Branch(branch), .Jump(jump), .ALUOp(alu_op),
    .LoadType(load_type), .StoreType(store_type), .IsMulDiv(is_muldiv),
    .Illegal(illegal), .busy(busy)
  );

  decode_issue_stage #(
    .ENABLE_M(1'b0), .MUL_LATENCY(4), .DIV_LATENCY(9), .CNT_W(6)
  ) u_dut_nom (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .instr(instr_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .RegWrite(reg_write_b), .ImmSrc(imm_src_b), .ALUSrc(alu_src_b), .MemWrite(mem_write_b),
    .ResultSrc(result_src_b), .Branch(branch_b), .Jump(jump_b), .ALUOp(alu_op_b),
    .LoadType(load_type_b), .StoreType(store_type_b), .IsMulDiv(is_muldiv_b),
    .Illegal(illegal_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  bit   pending;
  int   ready_at;
  int   cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference decoder written directly from the opcode/funct legality rules.
  function automatic exp_t ref_decode(input logic [31:0] w, input bit en_m,
                                      output int unsigned hold);
    exp_t       e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit         legal;
    e = '0; hold = 0;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    case (op)
      7'h03: legal = !(f3 inside {3'd3, 3'd6, 3'd7});
      7'h23: legal = (f3 <= 3'd2);
      7'h63: legal = !(f3 inside {3'd2, 3'd3});
      7'h67: legal = (f3 == 3'd0);
      7'h33: legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (f7 == 7'h01 && en_m);
      7'h13: legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                     (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      7'h37, 7'h17, 7'h6F: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.illegal = 1'b1;
      return e;
    end
    case (op)
      7'h03: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'd1; e.load_type = f3; end
      7'h23: begin e.mem_write = 1; e.imm_src = 3'd1; e.alu_src = 1; e.store_type = f3; end
      7'h33: begin
        e.reg_write = 1;
        if (f7 == 7'h01) begin
          e.alu_op = 3'd3; e.is_muldiv = 1;
          hold = f3[2] ? DIV_LAT : MUL_LAT;
        end else e.alu_op = 3'd2;
      end
      7'h13: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd2; end
      7'h63: begin e.imm_src = 3'd2; e.branch = 1; e.alu_op = 3'd1; end
      7'h6F: begin e.reg_write = 1; e.imm_src = 3'd4; e.result_src = 2'd2; e.jump = 1; e.alu_op = 3'd6; end
      7'h67: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'd2; e.jump = 1; end
      7'h37: begin e.reg_write = 1; e.imm_src = 3'd3; e.alu_src = 1; e.alu_op = 3'd4; end
      7'h17: begin e.reg_write = 1; e.imm_src = 3'd3; e.alu_src = 1; e.alu_op = 3'd5; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 15))
      0: w[6:0] = 7'h03;
      1: w[6:0] = 7'h23;
      2: w[6:0] = 7'h63;
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      5: w[6:0] = 7'h6F;
      6: begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 1) w[14:12] = 3'b000; end
      7, 8, 9, 10, 11: begin
        w[6:0] = ($urandom_range(0, 1) == 1) ? 7'h13 : 7'h33;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      12: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
      default: ;
    endcase
    return w;
  endfunction

  // One clock of stimulus; the model tracks when the held bundle becomes visible.
  task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
    exp_t        e;
    int unsigned hold;
    bit          exp_ov, exp_busy, exp_rdy;
    @(posedge clk);
    cyc++;
    #2;
    in_valid = v; instr = w; out_ready = ordy; flush = fl;
    #1;
    exp_ov   = pending && (cyc >= ready_at);
    exp_busy = pending && (cyc < ready_at);
    exp_rdy  = !fl && (!pending || (exp_ov && ordy));
    chk("out_valid", out_valid, exp_ov);
    chk("busy", busy, exp_busy);
    chk("in_ready", in_ready, exp_rdy);
    if (fl) begin
      pending = 0;
    end else if (v && exp_rdy) begin
      e = ref_decode(w, 1'b1, hold);
      sbq.push_back(e);
      pending  = 1;
      ready_at = cyc + 1 + int'(hold);
    end else if (exp_ov && ordy) begin
      pending = 0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1; in_valid = 0; flush = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_bundle", act_a, 0);
    pending = 0;
    sbq.delete();
    @(posedge clk);
    #3;
    rst = 0;
  endtask

  task automatic test_no_m();
    exp_t        e;
    int unsigned h;
    @(posedge clk); #2;
    in_valid_b = 1; instr_b = I_MUL; out_ready_b = 1; #1;
    chk("nom_in_ready", in_ready_b, 1);
    @(posedge clk); #2;
    instr_b = I_CUST; #1;
    e = ref_decode(I_MUL, 1'b0, h);
    chk("nom_mul_valid", out_valid_b, 1);
    chk("nom_mul_busy", busy_b, 0);
    chk("nom_mul_bundle", act_b, e);
    chk("nom_mul_illegal", illegal_b, 1);
    chk("nom_in_ready_full", in_ready_b, 1);
    @(posedge clk); #2;
    in_valid_b = 0; #1;
    e = ref_decode(I_CUST, 1'b0, h);
    chk("nom_cust_valid", out_valid_b, 1);
    chk("nom_cust_bundle", act_b, e);
    @(posedge clk); #3;
    chk("nom_drained", out_valid_b, 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bundle: got out_valid=1 bundle=0x%0h, required no bundle", act_a);
      end else begin
        chk("bundle", act_a, sbq[0]);
      end
    end
    if (flush) sbq.delete();
    else if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
  end

  initial begin
    rst = 1; flush = 0; in_valid = 1; instr = I_ADD; out_ready = 1;
    flush_b = 0; in_valid_b = 1; instr_b = I_ADD; out_ready_b = 1;
    pending = 0; ready_at = 0; cyc = 0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bundle", act_a, 0);
    chk("rst_in_ready_b", in_ready_b, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 0; in_valid = 0; in_valid_b = 0;

    test_no_m();

    step(1, I_ADD, 1, 0);
    step(0, '0, 1, 0);
    step(1, I_DIV, 1, 0);
    repeat (34) step(0, '0, 1, 0);
    step(1, I_LW, 1, 0);
    step(1, I_SW, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(1, I_ADDI, 1, 0);
    repeat (5) step(1, I_LW, 0, 0);
    step(1, I_LW, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(1, I_MUL, 1, 0);
    repeat (9) step(0, '0, 1, 0);
    step(0, '0, 1, 1);
    step(1, I_JAL, 1, 0);
    repeat (20) step(0, '0, 1, 0);
    step(1, I_ADD, 1, 1);
    step(0, '0, 1, 0);
    step(1, I_CUST, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    step(1, I_DIV, 1, 0);
    repeat (5) step(0, '0, 1, 0);
    pulse_reset();
    step(1, I_ADD, 0, 0);
    step(0, '0, 0, 0);
    pulse_reset();

    repeat (400) step($urandom_range(0, 9) < 7, rand_instr(),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);

    repeat (40) step(0, '0, 1, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
